scsi_initiator: RTL and testbench

- Initiator-side SCSI bus sequencer; the bus counterpart of the target-only SCSI device.
- For each host request it selects a target ID and sends a 6- or 10-byte CDB.
- It then moves data bytes in either direction, collects the status and message bytes, and reports completion.
- Used as the host end for target bring-up, and as the bus engine behind a simplified 5380-style controller.

---
 rtl/scsi_initiator.sv | 232 +++++++++++++++++++++++
 tb/tb_scsi_initiator.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scsi_initiator.sv
// Initiator-side SCSI bus sequencer: selects a target, sends a 6/10-byte CDB,
// moves data in either direction, collects status and message, reports completion.
module scsi_initiator #(
  parameter int unsigned SEL_TIMEOUT = 1024,
  parameter int unsigned ACK_HOLD    = 4,
  parameter int unsigned REQ_SETTLE  = 4,
  parameter int unsigned RST_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_tgt_id,
  input  logic [3:0]  i_cmd_len,
  output logic [3:0]  o_cmd_idx,
  input  logic [7:0]  i_cmd_byte,
  input  logic [7:0]  i_wr_data,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_valid,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_err,
  output logic [7:0]  o_status,
  output logic [7:0]  o_message,
  output logic [31:0] o_xfer_cnt,
  output logic        o_scsi_sel,
  output logic        o_scsi_atn,
  output logic        o_scsi_ack,
  output logic        o_scsi_rst,
  output logic [7:0]  o_scsi_dout,
  input  logic [7:0]  i_scsi_din,
  input  logic        i_scsi_bsy,
  input  logic        i_scsi_req,
  input  logic        i_scsi_msg,
  input  logic        i_scsi_cd,
  input  logic        i_scsi_io
);

  localparam logic [31:0] SelLast    = 32'(SEL_TIMEOUT - 1);
  localparam logic [31:0] AckLast    = 32'(ACK_HOLD - 1);
  localparam logic [31:0] SettleLast = 32'(REQ_SETTLE - 1);
  localparam logic [31:0] RstLast    = 32'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StSelect, StWaitReq, StAck, StSettle, StReset, StDone
  } state_e;

  state_e      r_state;
  logic [31:0] r_cnt;
  logic [3:0]  r_cmd_len;
  logic [3:0]  r_cmd_idx;
  logic        r_kind_cmd;
  logic        r_kind_data;
  logic [7:0]  r_rd_data;
  logic        r_rd_valid;
  logic        r_wr_ready;
  logic        r_busy;
  logic        r_done;
  logic [1:0]  r_err;
  logic [7:0]  r_status;
  logic [7:0]  r_message;
  logic [31:0] r_xfer_cnt;
  logic        r_sel;
  logic        r_ack;
  logic        r_rst;
  logic [7:0]  r_dout;

  logic w_ph_cmd, w_ph_dout, w_ph_din, w_ph_stat, w_ph_msg;
  logic w_overrun, w_accept, w_abort;

  assign w_ph_cmd  = i_scsi_cd & ~i_scsi_io;
  assign w_ph_dout = ~i_scsi_cd & ~i_scsi_io;
  assign w_ph_din  = ~i_scsi_cd & i_scsi_io;
  assign w_ph_stat = i_scsi_cd & i_scsi_io & ~i_scsi_msg;
  assign w_ph_msg  = i_scsi_cd & i_scsi_io & i_scsi_msg;

  assign w_overrun = w_ph_cmd && (r_cmd_idx >= r_cmd_len);
  // A data-out REQ is only taken once the host has a byte, so ACK never rises empty.
  assign w_accept  = i_scsi_req && !w_overrun && !(w_ph_dout && !i_wr_valid);
  assign w_abort   = i_abort && (r_state == StSelect || r_state == StWaitReq ||
                                 r_state == StAck || r_state == StSettle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_cmd_len   <= '0;
      r_cmd_idx   <= '0;
      r_kind_cmd  <= 1'b0;
      r_kind_data <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= '0;
      r_status    <= '0;
      r_message   <= '0;
      r_xfer_cnt  <= '0;
      r_sel       <= 1'b0;
      r_ack       <= 1'b0;
      r_rst       <= 1'b0;
      r_dout      <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_ready <= 1'b0;
      if (w_abort) begin
        r_err   <= 2'd3;
        r_sel   <= 1'b0;
        r_ack   <= 1'b0;
        r_dout  <= '0;
        r_rst   <= 1'b1;
        r_cnt   <= '0;
        r_state <= StReset;
      end else begin
        case (r_state)
          StIdle: begin
            if (i_start) begin
              r_cmd_len  <= i_cmd_len;
              r_cmd_idx  <= '0;
              r_status   <= '0;
              r_message  <= '0;
              r_xfer_cnt <= '0;
              r_err      <= '0;
              r_busy     <= 1'b1;
              r_sel      <= 1'b1;
              r_dout     <= 8'b1 << i_tgt_id;
              r_cnt      <= '0;
              r_state    <= StSelect;
            end
          end
          StSelect: begin
            if (i_scsi_bsy) begin
              r_sel   <= 1'b0;
              r_dout  <= '0;
              r_state <= StWaitReq;
            end else if (r_cnt == SelLast) begin
              r_sel   <= 1'b0;
              r_dout  <= '0;
              r_err   <= 2'd1;
              r_state <= StDone;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          StWaitReq: begin
            if (!i_scsi_bsy) begin
              r_state <= StDone;
            end else if (i_scsi_req && w_overrun) begin
              r_err   <= 2'd2;
              r_rst   <= 1'b1;
              r_cnt   <= '0;
              r_state <= StReset;
            end else if (w_accept) begin
              r_ack       <= 1'b1;
              r_cnt       <= '0;
              r_state     <= StAck;
              r_kind_cmd  <= w_ph_cmd;
              r_kind_data <= w_ph_dout | w_ph_din;
              if (w_ph_cmd) r_dout <= i_cmd_byte;
              if (w_ph_dout) begin
                r_dout     <= i_wr_data;
                r_wr_ready <= 1'b1;
              end
              if (w_ph_din) begin
                r_rd_data  <= i_scsi_din;
                r_rd_valid <= 1'b1;
              end
              if (w_ph_stat) r_status <= i_scsi_din;
              if (w_ph_msg) r_message <= i_scsi_din;
            end
          end
          StAck: begin
            if (r_cnt >= AckLast && !i_scsi_req) begin
              r_ack   <= 1'b0;
              r_cnt   <= '0;
              r_state <= StSettle;
              if (r_kind_cmd) r_cmd_idx <= r_cmd_idx + 4'd1;
              if (r_kind_data) r_xfer_cnt <= r_xfer_cnt + 32'd1;
            end else if (r_cnt < AckLast) begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          StSettle: begin
            // dout outlives ACK by one cycle for the target's delayed sample.
            if (r_cnt == 32'd0) r_dout <= '0;
            if (r_cnt >= SettleLast) begin
              r_state <= StWaitReq;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          StReset: begin
            if (i_abort) r_err <= 2'd3;
            if (r_cnt >= RstLast) begin
              r_rst   <= 1'b0;
              r_state <= StDone;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          StDone: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_cmd_idx   = r_cmd_idx;
  assign o_wr_ready  = r_wr_ready;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_status    = r_status;
  assign o_message   = r_message;
  assign o_xfer_cnt  = r_xfer_cnt;
  assign o_scsi_sel  = r_sel;
  assign o_scsi_atn  = 1'b0;
  assign o_scsi_ack  = r_ack;
  assign o_scsi_rst  = r_rst;
  assign o_scsi_dout = r_dout;

endmodule

// File: tb/tb_scsi_initiator.sv
// Scoreboard bench for scsi_initiator: a disk-image target model on the bus, a
// command-level reference model predicting read data and completion records.
module tb_scsi_initiator;

  localparam int unsigned SelTo    = 64;
  localparam int unsigned RstCyc   = 16;
  localparam int unsigned ImgBytes = 8 * 512;
  localparam int unsigned TgtId    = 0;
  localparam logic [2:0] PhCmd  = 3'b010;  // {msg, cd, io}
  localparam logic [2:0] PhDout = 3'b000;
  localparam logic [2:0] PhDin  = 3'b001;
  localparam logic [2:0] PhStat = 3'b011;
  localparam logic [2:0] PhMsg  = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [2:0]  tgt_id = '0;
  logic [3:0]  cmd_len = '0;
  logic [3:0]  cmd_idx;
  logic [7:0]  cmd_byte;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [1:0]  err;
  logic [7:0]  status, message;
  logic [31:0] xfer_cnt;
  logic        sel, atn, ack, srst;
  logic [7:0]  dout;
  logic [7:0]  t_din = '0;
  logic        t_bsy = 1'b0, t_req = 1'b0, t_msg = 1'b0, t_cd = 1'b0, t_io = 1'b0;

  logic [7:0] cdb [16];
  assign cmd_byte = cdb[cmd_idx];

  scsi_initiator #(
    .SEL_TIMEOUT(SelTo), .ACK_HOLD(4), .REQ_SETTLE(4), .RST_CYCLES(RstCyc)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_tgt_id(tgt_id), .i_cmd_len(cmd_len),
    .o_cmd_idx(cmd_idx), .i_cmd_byte(cmd_byte), .i_wr_data(wr_data), .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready), .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_err(err), .o_status(status), .o_message(message),
    .o_xfer_cnt(xfer_cnt), .o_scsi_sel(sel), .o_scsi_atn(atn), .o_scsi_ack(ack),
    .o_scsi_rst(srst), .o_scsi_dout(dout), .i_scsi_din(t_din), .i_scsi_bsy(t_bsy),
    .i_scsi_req(t_req), .i_scsi_msg(t_msg), .i_scsi_cd(t_cd), .i_scsi_io(t_io)
  );

  typedef struct {
    logic [1:0]  err;
    logic [7:0]  status;
    logic [7:0]  message;
    logic [31:0] xfer;
    logic [3:0]  idx;
  } done_t;

  done_t      done_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] tgt_img [ImgBytes];
  logic [7:0] ref_img [ImgBytes];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int exp_sel_w = 0;
  bit t_hit_rst = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic t_step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outcome of one command from the CDB alone.
  task automatic predict(input int unsigned abort_after);
    done_t e;
    int unsigned need, lba, n;
    logic [7:0] op, b;
    op = cdb[0];
    need = (op[7:5] == 3'd0) ? 6 : 10;
    e = '{err: 2'd0, status: 8'h00, message: 8'h00, xfer: 32'd0, idx: cmd_len};
    if (need > 32'(cmd_len)) begin
      e.err = 2'd2;
    end else begin
      lba = 32'({cdb[1][4:0], cdb[2], cdb[3]});
      n = 32'(cdb[4]) * 512;
      case (op)
        8'h00: ;
        8'h08: begin
          for (int unsigned i = 0; i < n; i++)
            if (abort_after == 0 || i < abort_after) rd_q.push_back(ref_img[lba * 512 + i]);
          e.xfer = (abort_after != 0) ? abort_after : n;
        end
        8'h0A: begin
          for (int unsigned i = 0; i < n; i++) begin
            b = 8'($urandom);
            wr_q.push_back(b);
            ref_img[lba * 512 + i] = b;
          end
          e.xfer = n;
        end
        default: e.status = 8'h02;
      endcase
      if (abort_after != 0) e.err = 2'd3;
    end
    done_q.push_back(e);
  endtask

  // One REQ/ACK byte from the target side; gives up when the bus is reset.
  task automatic t_xfer(input logic [2:0] ph, input logic [7:0] d, output logic [7:0] got);
    got = '0;
    if (t_hit_rst) return;
    {t_msg, t_cd, t_io} = ph;
    t_din = d;
    t_req = 1'b1;
    do t_step(); while (!ack && !srst);
    got = dout;
    t_req = 1'b0;
    if (srst) begin
      t_hit_rst = 1'b1;
      return;
    end
    do t_step(); while (ack && !srst);
    if (srst) t_hit_rst = 1'b1;
  endtask

  initial begin : target
    logic [7:0] c [10];
    logic [7:0] v, st;
    int need;
    int unsigned lba, n;
    forever begin
      t_step();
      if (sel && dout[TgtId] && !srst) begin
        t_hit_rst = 1'b0;
        t_bsy = 1'b1;
        do t_step(); while (sel);
        t_xfer(PhCmd, 8'h00, c[0]);
        need = (c[0][7:5] == 3'd0) ? 6 : 10;
        for (int i = 1; i < need; i++) t_xfer(PhCmd, 8'h00, c[i]);
        st = 8'h00;
        if (!t_hit_rst) begin
          lba = 32'({c[1][4:0], c[2], c[3]});
          n = 32'(c[4]) * 512;
          case (c[0])
            8'h00: ;
            8'h08: for (int unsigned i = 0; i < n; i++) t_xfer(PhDin, tgt_img[lba * 512 + i], v);
            8'h0A: for (int unsigned i = 0; i < n; i++) begin
              t_xfer(PhDout, 8'h00, v);
              if (!t_hit_rst) tgt_img[lba * 512 + i] = v;
            end
            default: st = 8'h02;
          endcase
        end
        t_xfer(PhStat, st, v);
        t_xfer(PhMsg, 8'h00, v);
        t_bsy = 1'b0;
        t_req = 1'b0;
        {t_msg, t_cd, t_io} = 3'b000;
        if (t_hit_rst) while (srst) t_step();
      end
    end
  end

  initial begin : host_wr
    int gap;
    forever begin
      t_step();
      if (wr_valid && wr_ready) begin
        wr_valid = 1'b0;
        void'(wr_q.pop_front());
        gap = 3 + $urandom_range(0, 12);
        repeat (gap - 1) t_step();
      end else if (!wr_valid && wr_q.size() != 0) begin
        wr_data = wr_q[0];
        wr_valid = 1'b1;
      end
    end
  end

  initial begin : monitor
    done_t e;
    int sel_w, rst_w, cmd_seen;
    logic ack_q, sel_q, rst_q;
    sel_w = 0; rst_w = 0; cmd_seen = 0;
    ack_q = 1'b0; sel_q = 1'b0; rst_q = 1'b0;
    forever begin
      @(negedge clk);
      if (start) cmd_seen = 0;
      if (rd_valid) begin
        rd_cnt++;
        if (rd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_extra: got byte 0x%0h, want no read byte", rd_data);
        end else begin
          check("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
        end
      end
      if (wr_ready) wr_cnt++;
      if (ack && !ack_q) begin
        if (t_cd && !t_io) begin
          check("cmd_idx_step", 64'(cmd_idx), 64'(cmd_seen));
          cmd_seen++;
        end else if (!t_cd && !t_io) begin
          check("ack_has_data", 64'(wr_ready), 64'd1);
        end
      end
      if (sel) begin
        sel_w++;
      end else if (sel_q) begin
        if (exp_sel_w != 0) check("sel_width", 64'(sel_w), 64'(exp_sel_w));
        sel_w = 0;
      end
      if (srst) begin
        rst_w++;
      end else if (rst_q) begin
        check("rst_width", 64'(rst_w), 64'(RstCyc));
        rst_w = 0;
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_extra: got done with err %0d, want no done", err);
        end else begin
          e = done_q.pop_front();
          check("done_err", 64'(err), 64'(e.err));
          check("done_status", 64'(status), 64'(e.status));
          check("done_message", 64'(message), 64'(e.message));
          check("done_xfer_cnt", 64'(xfer_cnt), 64'(e.xfer));
          check("done_cmd_idx", 64'(cmd_idx), 64'(e.idx));
          check("done_busy_low", 64'(busy), 64'd0);
          check("done_bus_free", 64'({t_bsy, srst, sel, ack}), 64'd0);
        end
      end
      ack_q = ack; sel_q = sel; rst_q = srst;
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got no finish after 90000 cycles, want finish");
    $fatal(1, "bench did not complete");
  end

  task automatic set_cdb(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
    for (int i = 0; i < 16; i++) cdb[i] = 8'h00;
    cdb[0] = b0; cdb[1] = b1; cdb[2] = b2; cdb[3] = b3; cdb[4] = b4;
  endtask

  task automatic run(input logic [2:0] id, input logic [3:0] len, input int unsigned abort_after,
                     input bit abort_at_start);
    int d0, r0, budget;
    bit sent;
    d0 = done_cnt; r0 = rd_cnt; budget = 0; sent = 1'b0;
    tgt_id = id; cmd_len = len; start = 1'b1; abort = abort_at_start;
    t_step();
    start = 1'b0; abort = 1'b0;
    while (done_cnt == d0 && budget < 40000) begin
      if (abort_after != 0 && !sent && (rd_cnt - r0) >= int'(abort_after) && !ack) begin
        abort = 1'b1;
        t_step();
        abort = 1'b0;
        sent = 1'b1;
      end else begin
        t_step();
      end
      budget++;
    end
    if (done_cnt == d0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done in %0d cycles, want done", budget);
    end
    repeat (3) t_step();
  endtask

  initial begin : main
    logic [7:0] b;
    int bad_bytes, w0;
    logic [7:0] lba_a, lba_r;
    for (int i = 0; i < int'(ImgBytes); i++) begin
      b = 8'($urandom);
      tgt_img[i] = b;
      ref_img[i] = b;
    end
    set_cdb(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1 rst_n = 1'b0;
    repeat (3) t_step();
    check("reset_ctrl", 64'({busy, done, err, sel, atn, ack, srst, wr_ready, rd_valid, dout}), 64'd0);
    check("reset_regs", 64'({cmd_idx, status, message, xfer_cnt}), 64'd0);
    rst_n = 1'b1;
    repeat (2) t_step();

    abort = 1'b1;
    t_step();
    abort = 1'b0;
    repeat (2) t_step();
    check("idle_abort_ignored", 64'({busy, srst, sel}), 64'd0);

    // No target answers ID 6: selection times out.
    exp_sel_w = SelTo;
    done_q.push_back('{err: 2'd1, status: 8'h00, message: 8'h00, xfer: 32'd0, idx: 4'd0});
    run(3'd6, 4'd6, 0, 1'b0);
    exp_sel_w = 0;

    // TEST UNIT READY, with abort arriving together with start.
    set_cdb(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    cmd_len = 4'd6;
    predict(0);
    run(3'(TgtId), 4'd6, 0, 1'b1);

    set_cdb(8'h08, 8'h00, 8'h00, 8'h05, 8'h01);
    cmd_len = 4'd6;
    predict(0);
    run(3'(TgtId), 4'd6, 0, 1'b0);

    set_cdb(8'h0A, 8'h00, 8'h00, 8'h02, 8'h02);
    cmd_len = 4'd6;
    w0 = wr_cnt;
    predict(0);
    run(3'(TgtId), 4'd6, 0, 1'b0);
    check("wr_ready_pulses", 64'(wr_cnt - w0), 64'd1024);
    bad_bytes = 0;
    for (int i = 2 * 512; i < 4 * 512; i++) if (tgt_img[i] !== ref_img[i]) bad_bytes++;
    check("image_write_bytes_wrong", 64'(bad_bytes), 64'd0);

    lba_r = 8'($urandom_range(2, 3));
    set_cdb(8'h08, 8'h00, 8'h00, lba_r, 8'h01);
    cmd_len = 4'd6;
    predict(0);
    run(3'(TgtId), 4'd6, 0, 1'b0);

    set_cdb(8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
    cmd_len = 4'd6;
    predict(0);
    run(3'(TgtId), 4'd6, 0, 1'b0);

    // Ten-byte CDB of an opcode the target does not support.
    set_cdb(8'h25, 8'h00, 8'h00, 8'h00, 8'h00);
    cmd_len = 4'd10;
    predict(0);
    run(3'(TgtId), 4'd10, 0, 1'b0);

    // Group-7 opcode with a 6-byte CDB: target asks for a seventh byte.
    set_cdb(8'hE0, 8'h00, 8'h00, 8'h00, 8'h00);
    cmd_len = 4'd6;
    predict(0);
    run(3'(TgtId), 4'd6, 0, 1'b0);

    lba_a = 8'($urandom_range(0, 4));
    set_cdb(8'h08, 8'h00, 8'h00, lba_a, 8'h04);
    cmd_len = 4'd6;
    predict(100);
    run(3'(TgtId), 4'd6, 100, 1'b0);

    repeat (5) t_step();
    check("rd_queue_left", 64'(rd_q.size()), 64'd0);
    check("done_queue_left", 64'(done_q.size()), 64'd0);
    check("wr_queue_left", 64'(wr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
